// File: rtl/tc_mem_pkg.sv
// Shared definitions for the TotalCoeff memory scheduler: FSM encoding,
// fill-mode codes and the bottom-row block index table.
package tc_mem_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DRAIN   = 3'd1;
    localparam logic [2:0] ST_COPY_RD = 3'd2;
    localparam logic [2:0] ST_COPY_WR = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_FILL_A  = 3'd5;

    localparam logic [1:0] FILL_COPY = 2'd0;
    localparam logic [1:0] FILL_ZERO = 2'd1;
    localparam logic [1:0] FILL_PCM  = 2'd2;

    localparam logic [4:0] TC_PCM_VAL = 5'd16;
    localparam logic [3:0] BOT_LAST   = 4'd11;
    localparam int unsigned TC_A_LAST = 49;

    // Blocks on the bottom edge of the MB, in copy order
    function automatic logic [5:0] bot_idx(input logic [3:0] i);
        case (i)
            4'd0:    bot_idx = 6'd10;
            4'd1:    bot_idx = 6'd11;
            4'd2:    bot_idx = 6'd14;
            4'd3:    bot_idx = 6'd15;
            4'd4:    bot_idx = 6'd28;
            4'd5:    bot_idx = 6'd29;
            4'd6:    bot_idx = 6'd32;
            4'd7:    bot_idx = 6'd33;
            4'd8:    bot_idx = 6'd44;
            4'd9:    bot_idx = 6'd45;
            4'd10:   bot_idx = 6'd48;
            4'd11:   bot_idx = 6'd49;
            default: bot_idx = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/tc_wr_fifo.sv
// Write-back queue of {idx, tc} pairs. A push while full is accepted only
// when a pop happens in the same cycle.
module tc_wr_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 11
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_push_ok
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_cnt;
    logic          w_pop_ok;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (PW+1)'(DEPTH));
    assign o_data    = r_mem[r_rp];
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (o_push_ok) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop_ok)
                r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (PW+1)'(o_push_ok) - (PW+1)'(w_pop_ok);
        end
    end

endmodule

// File: rtl/tc_mem_sched.sv
// TotalCoeff neighbour memory scheduler: arbitrates nC reads, block write-backs
// and the end-of-MB bottom-row copy onto TC_A/TC_B. Option: TC_MEM_FILL_EN.
module tc_mem_sched
    import tc_mem_pkg::*;
#(
    parameter int unsigned TC_W     = 5,
    parameter int unsigned A_AW     = 6,
    parameter int unsigned MBH_W    = 7,
    parameter int unsigned WQ_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rd_req,
    input  logic [A_AW-1:0]       rd_a_addr,
    input  logic [MBH_W+A_AW-1:0] rd_b_addr,
    input  logic                  wr_req,
    input  logic [A_AW-1:0]       wr_idx,
    input  logic [TC_W-1:0]       wr_tc,
    input  logic                  mb_done,
    input  logic [7:0]            mb_num_h,
    input  logic [1:0]            fill_mode,
    output logic [A_AW-1:0]       tca_addr,
    output logic                  tca_we,
    output logic [TC_W-1:0]       tca_din,
    output logic [MBH_W+A_AW-1:0] tcb_addr,
    output logic                  tcb_we,
    output logic [TC_W-1:0]       tcb_din,
    input  logic [TC_W-1:0]       tca_dout,
    output logic                  wq_full,
    output logic                  busy
);
    logic [2:0]       r_state;
    logic [3:0]       r_cidx;
    logic [A_AW-1:0]  r_fidx;
    logic [MBH_W-1:0] r_mbh;
    logic [1:0]       r_fill;
    logic             r_busy;
    logic [TC_W-1:0]  r_cap;
    logic             r_rd_grant;

    logic             w_pop;
    logic             w_empty;
    logic             w_push_ok;
    logic [A_AW-1:0]  w_q_idx;
    logic [TC_W-1:0]  w_q_tc;
    logic [A_AW-1:0]  w_bot;
    logic [TC_W-1:0]  w_fill_val;
    logic [TC_W-1:0]  w_wr_data;
    logic [1:0]       w_fill_sel;
    logic             w_unused;

    tc_wr_fifo #(
        .DEPTH (WQ_DEPTH),
        .W     (A_AW + TC_W)
    ) u_wq (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_push    (wr_req),
        .i_pop     (w_pop),
        .i_data    ({wr_idx, wr_tc}),
        .o_data    ({w_q_idx, w_q_tc}),
        .o_empty   (w_empty),
        .o_full    (wq_full),
        .o_push_ok (w_push_ok)
    );

`ifdef TC_MEM_FILL_EN
    assign w_fill_sel = (fill_mode == FILL_ZERO || fill_mode == FILL_PCM) ? fill_mode : FILL_COPY;
    assign w_unused   = ^(mb_num_h >> MBH_W);
`else
    assign w_fill_sel = FILL_COPY;
    assign w_unused   = ^{mb_num_h >> MBH_W, fill_mode};
`endif

    assign busy       = r_busy;
    assign w_bot      = A_AW'(bot_idx(r_cidx));
    assign w_fill_val = (r_fill == FILL_PCM) ? TC_W'(TC_PCM_VAL) : '0;
    assign w_pop      = !rd_req && !w_empty && (r_state == ST_IDLE || r_state == ST_DRAIN);
    // Read data is live only on the cycle after the grant; stalled writes use the copy
    assign w_wr_data  = (r_fill != FILL_COPY) ? w_fill_val :
                        (r_rd_grant ? tca_dout : r_cap);

    always_comb begin
        tca_addr = '0;
        tca_we   = 1'b0;
        tca_din  = '0;
        tcb_addr = '0;
        tcb_we   = 1'b0;
        tcb_din  = '0;
        if (rd_req) begin
            tca_addr = rd_a_addr;
            tcb_addr = rd_b_addr;
        end else begin
            if (r_state == ST_COPY_RD) begin
                tca_addr = w_bot;
            end else if (r_state == ST_FILL_A) begin
                tca_addr = r_fidx;
                tca_we   = 1'b1;
                tca_din  = w_fill_val;
            end else if (w_pop) begin
                tca_addr = w_q_idx;
                tca_we   = 1'b1;
                tca_din  = w_q_tc;
            end
            if (r_state == ST_COPY_WR) begin
                tcb_addr = {r_mbh, w_bot};
                tcb_we   = 1'b1;
                tcb_din  = w_wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state    <= ST_IDLE;
            r_cidx     <= '0;
            r_fidx     <= '0;
            r_mbh      <= '0;
            r_fill     <= FILL_COPY;
            r_busy     <= 1'b0;
            r_cap      <= '0;
            r_rd_grant <= 1'b0;
        end else begin
            r_rd_grant <= 1'b0;
            if (r_rd_grant)
                r_cap <= tca_dout;
            case (r_state)
                ST_IDLE: begin
                    if (mb_done) begin
                        r_state <= ST_DRAIN;
                        r_busy  <= 1'b1;
                        r_mbh   <= mb_num_h[MBH_W-1:0];
                        r_fill  <= w_fill_sel;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty && !w_push_ok)
                        r_state <= (r_fill == FILL_COPY) ? ST_COPY_RD : ST_COPY_WR;
                end
                ST_COPY_RD: begin
                    if (!rd_req) begin
                        r_state    <= ST_COPY_WR;
                        r_rd_grant <= 1'b1;
                    end
                end
                ST_COPY_WR: begin
                    if (!rd_req) begin
                        if (r_cidx == BOT_LAST) begin
                            r_cidx  <= '0;
                            r_state <= (r_fill == FILL_COPY) ? ST_DONE : ST_FILL_A;
                        end else begin
                            r_cidx <= r_cidx + 4'd1;
                            if (r_fill == FILL_COPY)
                                r_state <= ST_COPY_RD;
                        end
                    end
                end
                ST_FILL_A: begin
                    if (!rd_req) begin
                        if (r_fidx == A_AW'(TC_A_LAST)) begin
                            r_fidx  <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_fidx <= r_fidx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_cidx  <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tc_mem_sched.sv
// Self-checking bench for tc_mem_sched with behavioural TC_A RAM and a
// transaction-level reference of the bottom-row copy/fill.
module tb_tc_mem_sched;

    logic        clk = 1'b0;
    logic        reset_n, rd_req, wr_req, mb_done;
    logic [5:0]  rd_a_addr, wr_idx, tca_addr;
    logic [12:0] rd_b_addr, tcb_addr;
    logic [4:0]  wr_tc, tca_din, tcb_din, tca_dout;
    logic [7:0]  mb_num_h;
    logic [1:0]  fill_mode;
    logic        tca_we, tcb_we, wq_full, busy;

    logic [4:0]  ram_a [64];
    int          ref_a [64];
    int          bot [12] = '{10, 11, 14, 15, 28, 29, 32, 33, 44, 45, 48, 49};
    int          n_chk = 0;
    int          n_fail = 0;
    int          viol = 0;
    bit          saw_full = 0;

    always #5 clk = ~clk;

    tc_mem_sched #(
        .TC_W(5), .A_AW(6), .MBH_W(7), .WQ_DEPTH(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_a_addr(rd_a_addr),
        .rd_b_addr(rd_b_addr), .wr_req(wr_req), .wr_idx(wr_idx), .wr_tc(wr_tc),
        .mb_done(mb_done), .mb_num_h(mb_num_h), .fill_mode(fill_mode),
        .tca_addr(tca_addr), .tca_we(tca_we), .tca_din(tca_din),
        .tcb_addr(tcb_addr), .tcb_we(tcb_we), .tcb_din(tcb_din),
        .tca_dout(tca_dout), .wq_full(wq_full), .busy(busy)
    );

    // Single-port TC_A macro, read-first, one-cycle read latency
    always @(posedge clk) begin
        if (tca_we) ram_a[tca_addr] <= tca_din;
        tca_dout <= ram_a[tca_addr];
    end

    // While an nC read is asserted it must own both ports and nothing may be written
    always @(negedge clk) begin
        if (rd_req && (tca_we || tcb_we || tca_addr !== rd_a_addr || tcb_addr !== rd_b_addr))
            viol++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input int tc);
        int  guard = 0;
        bit  acc = 0;
        wr_req = 1'b1;
        wr_idx = 6'(idx);
        wr_tc  = 5'(tc);
        while (!acc && guard < 100) begin
            @(negedge clk);
            if (wq_full) saw_full = 1;
            acc = !wq_full || tca_we;
            step();
            guard++;
        end
        wr_req = 1'b0;
        if (!acc) check_eq($sformatf("push_timeout_%0d", idx), 0, 1);
        ref_a[idx] = tc;
    endtask

    task automatic settle();
        repeat (4) step();
    endtask

    task automatic check_ram_a(input string tag);
        for (int i = 0; i < 50; i++)
            check_eq($sformatf("%s_a%0d", tag, i), int'(ram_a[i]), ref_a[i]);
    endtask

    task automatic run_mb(input logic [7:0] mbh, input logic [1:0] fm, input bit stalls,
                          input bit dup_done, input bit do_rst, input string tag);
        int  c = 0, nwr = 0, nstall = 0, busy_n = 0, extra = 0, exp_busy;
        bit  rst_fired = 0, fill_on, ended = 0;
        int  fillv;
        int  log_a [$];
        int  log_d [$];
`ifdef TC_MEM_FILL_EN
        fill_on = (fm == 2'd1 || fm == 2'd2);
`else
        fill_on = 0;
`endif
        fillv = (fm == 2'd2) ? 16 : 0;
        mb_done = 1'b1; mb_num_h = mbh; fill_mode = fm;
        step();
        mb_done = 1'b0; mb_num_h = 8'($urandom); fill_mode = 2'($urandom);
        while (c < 400) begin
            rd_req = 1'b0; reset_n = 1'b0;
            if (stalls && c >= 1 && nwr < 12 && $urandom_range(0, 2) == 0) begin
                rd_req = 1'b1; rd_a_addr = 6'($urandom); rd_b_addr = 13'($urandom);
                nstall++;
            end
            if (dup_done) mb_done = (c == 5);
            if (do_rst && !rst_fired && nwr == 4) begin
                reset_n = 1'b1; rst_fired = 1;
            end
            @(negedge clk);
            if (!busy) begin ended = 1; break; end
            busy_n++;
            if (tcb_we) begin
                log_a.push_back(int'(tcb_addr)); log_d.push_back(int'(tcb_din)); nwr++;
            end
            step();
            c++;
        end
        if (!ended) check_eq({tag, "_busy_timeout"}, 0, 1);
        if (do_rst) begin
            check_eq({tag, "_wr_before_rst"}, nwr, 4);
            check_eq({tag, "_tca_we_after_rst"}, int'(tca_we), 0);
            check_eq({tag, "_tcb_we_after_rst"}, int'(tcb_we), 0);
            repeat (20) begin
                step();
                @(negedge clk);
                if (tcb_we || busy) extra++;
            end
            check_eq({tag, "_quiet_after_rst"}, extra, 0);
        end else begin
            exp_busy = fill_on ? 64 : 26 + nstall;
            check_eq({tag, "_busy_cycles"}, busy_n, exp_busy);
            check_eq({tag, "_n_tcb_wr"}, log_a.size(), 12);
            for (int k = 0; k < 12 && k < log_a.size(); k++) begin
                check_eq($sformatf("%s_addr%0d", tag, k), log_a[k], int'(mbh % 128) * 64 + bot[k]);
                check_eq($sformatf("%s_data%0d", tag, k), log_d[k], fill_on ? fillv : ref_a[bot[k]]);
            end
            if (fill_on)
                for (int i = 0; i < 50; i++) ref_a[i] = fillv;
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin ram_a[i] = '0; ref_a[i] = 0; end
        reset_n = 1'b1; rd_req = 1'b0; wr_req = 1'b0; mb_done = 1'b0;
        rd_a_addr = '0; rd_b_addr = '0; wr_idx = '0; wr_tc = '0;
        mb_num_h = '0; fill_mode = '0;
        repeat (3) step();
        @(negedge clk);
        check_eq("rst_tca_addr", int'(tca_addr), 0);
        check_eq("rst_tca_we", int'(tca_we), 0);
        check_eq("rst_tca_din", int'(tca_din), 0);
        check_eq("rst_tcb_addr", int'(tcb_addr), 0);
        check_eq("rst_tcb_we", int'(tcb_we), 0);
        check_eq("rst_tcb_din", int'(tcb_din), 0);
        check_eq("rst_wq_full", int'(wq_full), 0);
        check_eq("rst_busy", int'(busy), 0);
        step();
        reset_n = 1'b0;
        step();

        // Queued write lands one cycle after the push, then reads back
        push(10, 3);
        @(negedge clk);
        check_eq("pop_we", int'(tca_we), 1);
        check_eq("pop_addr", int'(tca_addr), 10);
        check_eq("pop_din", int'(tca_din), 3);
        step();
        rd_req = 1'b1; rd_a_addr = 6'd10;
        step();
        rd_req = 1'b0;
        @(negedge clk);
        check_eq("rd_back", int'(tca_dout), 3);
        step();

        // Reads block pops; the producer must hold through wq_full
        fork
            begin
                for (int i = 0; i < 4; i++) push(20 + i, 7 + i);
            end
            begin
                rd_req = 1'b1; rd_a_addr = 6'd0; rd_b_addr = 13'd0;
                repeat (6) step();
                rd_req = 1'b0;
            end
        join
        settle();
        check_eq("saw_wq_full", int'(saw_full), 1);
        for (int i = 20; i < 24; i++)
            check_eq($sformatf("q_entry_%0d", i), int'(ram_a[i]), ref_a[i]);

        for (int i = 0; i < 50; i++) push(i, $urandom_range(0, 16));
        settle();
        check_ram_a("init");

        run_mb(8'd5, 2'd0, 0, 0, 0, "copy_mbh5");
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 12; k++) push(bot[k], $urandom_range(0, 16));
            settle();
            run_mb(8'($urandom), 2'd0, 1, it == 1, 0, $sformatf("copy_rnd%0d", it));
        end

        run_mb(8'd0, 2'd2, 0, 0, 0, "fill_pcm");
        settle();
        check_ram_a("after_pcm");
        run_mb(8'h85, 2'd1, 0, 0, 0, "fill_zero");
        settle();
        check_ram_a("after_zero");

        for (int k = 0; k < 12; k++) push(bot[k], $urandom_range(1, 16));
        settle();
        run_mb(8'd3, 2'd0, 0, 0, 1, "reset_mid");

        check_eq("rd_port_violations", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
